// File: rtl/boton_pkg.sv
// Shared encodings for the button press classifier and the event arbiter.
package boton_pkg;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_PRESSED   = 2'd1;
  localparam logic [1:0] S_LONG_HELD = 2'd2;

  localparam logic A_IDLE  = 1'b0;
  localparam logic A_OFFER = 1'b1;

  localparam logic EV_SHORT = 1'b0;
  localparam logic EV_LONG  = 1'b1;

endpackage

// File: rtl/boton_press_fsm.sv
// One button: edge detect, hold counter and press FSM producing one-cycle short/long strobes.
// Auto-repeat of long events while held is enabled by defining BOTON_AUTOREPEAT_EN.
module boton_press_fsm
  import boton_pkg::*;
#(
  parameter int LONG_CYC   = 5000,
  parameter int REPEAT_CYC = 2500
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic short_stb,
  output logic long_stb
);

  localparam int CW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] CNT_ARM = CW'(LONG_CYC - 2);

  if (LONG_CYC < 2 || REPEAT_CYC < 1) begin : g_cfg_chk
    $error("boton_press_fsm: LONG_CYC must be >= 2 and REPEAT_CYC >= 1");
  end

  logic [1:0]    state;
  logic          level_q;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          hit_long;

  assign rise      = level & ~level_q;
  // Strobes are combinational so the pending flag is set on the very edge
  // that sees the release or the threshold.
  assign hit_long  = (state == S_PRESSED) && level && (cnt == CNT_ARM);
  assign short_stb = (state == S_PRESSED) && !level;

`ifdef BOTON_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  logic [RW-1:0] rpt_cnt;
  logic          hit_rpt;

  assign hit_rpt  = (state == S_LONG_HELD) && level && (rpt_cnt == RW'(REPEAT_CYC - 1));
  assign long_stb = hit_long | hit_rpt;

  always_ff @(posedge clk) begin
    if (reset || hit_long || hit_rpt) rpt_cnt <= '0;
    else if (state == S_LONG_HELD && level) rpt_cnt <= rpt_cnt + 1'b1;
  end
`else
  assign long_stb = hit_long;
`endif

  // NOTE: sequential state uses nonblocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      level_q <= level;  // a button held through reset must not look like a new press
    end else begin
      level_q <= level;
      case (state)
        S_IDLE: begin
          if (rise) begin
            state <= S_PRESSED;
            cnt   <= '0;
          end
        end
        S_PRESSED: begin
          if (!level) begin
            state <= S_IDLE;
          end else begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (hit_long) state <= S_LONG_HELD;
          end
        end
        S_LONG_HELD: begin
          if (!level) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/boton_event_arbiter.sv
// Classifies button presses, holds one pending short/long flag per button and
// serializes them round-robin onto a valid/ready channel. Optional: BOTON_AUTOREPEAT_EN.
module boton_event_arbiter
  import boton_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int LONG_CYC   = 5000,
  parameter int REPEAT_CYC = 2500,
  localparam int BW        = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_level,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [BW-1:0]    ev_btn,
  output logic             ev_long,
  output logic             ev_overflow
);

  if (N_BTN < 2 || N_BTN > 8) begin : g_cfg_chk
    $error("boton_event_arbiter: N_BTN must be in 2..8");
  end

  logic [N_BTN-1:0] short_stb, long_stb;
  logic [N_BTN-1:0] pend_s, pend_l, pend_any;
  logic [N_BTN-1:0] clr_s, clr_l;
  logic             arb_state;
  logic [BW-1:0]    rr;
  logic [BW-1:0]    pick;
  logic [BW-1:0]    scan_idx;
  logic             pick_vld;
  logic             grant;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    boton_press_fsm #(
      .LONG_CYC  (LONG_CYC),
      .REPEAT_CYC(REPEAT_CYC)
    ) u_press_fsm (
      .clk      (clk),
      .reset    (reset),
      .level    (btn_level[i]),
      .short_stb(short_stb[i]),
      .long_stb (long_stb[i])
    );
  end

  assign pend_any = pend_s | pend_l;
  assign grant    = (arb_state == A_IDLE) && pick_vld;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < N_BTN; k++) begin
      scan_idx = (int'(rr) + k >= N_BTN) ? BW'(int'(rr) + k - N_BTN) : BW'(int'(rr) + k);
      if (!pick_vld && pend_any[scan_idx]) begin
        pick_vld = 1'b1;
        pick     = scan_idx;
      end
    end
  end

  always_comb begin
    clr_s = '0;
    clr_l = '0;
    if (grant) begin
      if (pend_l[pick]) clr_l[pick] = 1'b1;
      else              clr_s[pick] = 1'b1;
    end
  end

  // A slot being granted this cycle counts as free, so a new event lands there
  // without raising overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_s      <= '0;
      pend_l      <= '0;
      ev_overflow <= 1'b0;
    end else begin
      pend_s <= (pend_s & ~clr_s) | short_stb;
      pend_l <= (pend_l & ~clr_l) | long_stb;
      if (|((pend_s & ~clr_s & short_stb) | (pend_l & ~clr_l & long_stb)))
        ev_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arb_state <= A_IDLE;
      rr        <= '0;
      ev_valid  <= 1'b0;
      ev_btn    <= '0;
      ev_long   <= 1'b0;
    end else begin
      case (arb_state)
        A_IDLE: begin
          if (pick_vld) begin
            ev_btn    <= pick;
            ev_long   <= pend_l[pick] ? EV_LONG : EV_SHORT;
            ev_valid  <= 1'b1;
            arb_state <= A_OFFER;
          end
        end
        A_OFFER: begin
          if (ev_ready) begin
            ev_valid  <= 1'b0;
            rr        <= (ev_btn == BW'(N_BTN - 1)) ? '0 : ev_btn + 1'b1;
            arb_state <= A_IDLE;
          end
        end
        default: arb_state <= A_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boton_event_arbiter.sv
// Scoreboard bench for boton_event_arbiter: directed presses push expected events,
// a negedge monitor pops and compares on every handshake.
module tb_boton_event_arbiter;

  localparam int N_BTN      = 4;
  localparam int LONG_CYC   = 20;
  localparam int REPEAT_CYC = 10;
  localparam int BW         = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_BTN-1:0] btn_level;
  logic             ev_ready;
  logic             ev_valid;
  logic [BW-1:0]    ev_btn;
  logic             ev_long;
  logic             ev_overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int btn;
    int lng;
    int at;   // expected monitor cycle, -1 = not timed
  } exp_t;

  exp_t exp_q[$];

  logic          stall_vld = 1'b0;
  logic [BW-1:0] stall_btn;
  logic          stall_long;

  boton_event_arbiter #(
    .N_BTN     (N_BTN),
    .LONG_CYC  (LONG_CYC),
    .REPEAT_CYC(REPEAT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_level  (btn_level),
    .ev_ready   (ev_ready),
    .ev_valid   (ev_valid),
    .ev_btn     (ev_btn),
    .ev_long    (ev_long),
    .ev_overflow(ev_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int btn, input int lng, input int at);
    exp_t e;
    e.btn = btn;
    e.lng = lng;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && exp_q.size() > 0; i++) step(1);
    check(name, exp_q.size(), 0);
    step(4);
  endtask

  task automatic check_idle_outputs(input string tag, input int ovf);
    check({tag, "_valid"}, int'(ev_valid), 0);
    check({tag, "_btn"}, int'(ev_btn), 0);
    check({tag, "_long"}, int'(ev_long), 0);
    check({tag, "_ovf"}, int'(ev_overflow), ovf);
  endtask

  // Monitor: compare each handshake against the scoreboard, and hold-stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (stall_vld && ev_valid) begin
      check("stall_btn_stable", int'(ev_btn), int'(stall_btn));
      check("stall_long_stable", int'(ev_long), int'(stall_long));
    end
    if (ev_valid && ev_ready) begin
      stall_vld <= 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected_event", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("ev_btn", int'(ev_btn), e.btn);
        check("ev_long", int'(ev_long), e.lng);
        if (e.at >= 0) check("ev_timing", cyc, e.at);
      end
    end else if (ev_valid) begin
      stall_vld  <= 1'b1;
      stall_btn  <= ev_btn;
      stall_long <= ev_long;
    end else begin
      stall_vld <= 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    btn_level = '0;
    ev_ready  = 1'b1;
    step(3);
    check_idle_outputs("reset", 0);
    reset = 1'b0;
    step(2);

    // 1: short press on button 2
    btn_level[2] = 1'b1;
    step(5);
    btn_level[2] = 1'b0;
    push(2, 0, cyc + 2);
    drain("t1_drain");

    // 2: long press on button 1, event fires while held, nothing on release
    btn_level[1] = 1'b1;
    push(1, 1, cyc + 21);
    step(40);
    btn_level[1] = 1'b0;
    step(10);
    drain("t2_drain");

    // 3: simultaneous shorts on 0 and 3 with RR pointer at 2, consumer stalls
    ev_ready     = 1'b0;
    btn_level[0] = 1'b1;
    btn_level[3] = 1'b1;
    step(4);
    btn_level[0] = 1'b0;
    btn_level[3] = 1'b0;
    push(3, 0, -1);
    push(0, 0, -1);
    step(2);
    check("t3_first_valid", int'(ev_valid), 1);
    check("t3_first_btn", int'(ev_btn), 3);
    step(7);
    ev_ready = 1'b1;
    drain("t3_drain");

    // 4: overflow on button 0 while button 1 is stuck in the offer
    ev_ready     = 1'b0;
    btn_level[1] = 1'b1;
    step(2);
    btn_level[1] = 1'b0;
    push(1, 0, -1);
    step(4);
    btn_level[0] = 1'b1;
    step(2);
    btn_level[0] = 1'b0;
    push(0, 0, -1);
    step(3);
    check("t4_no_ovf_yet", int'(ev_overflow), 0);
    btn_level[0] = 1'b1;
    step(2);
    btn_level[0] = 1'b0;
    step(3);
    check("t4_ovf_set", int'(ev_overflow), 1);
    ev_ready = 1'b1;
    drain("t4_drain");
    check("t4_ovf_sticky", int'(ev_overflow), 1);

    // 5: reset mid-press discards it; a button held through reset is ignored
    btn_level[3] = 1'b1;
    step(10);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_idle_outputs("t5_after_reset", 0);
    btn_level[3] = 1'b0;
    step(10);
    check("t5_no_event", int'(ev_valid), 0);
    btn_level[2] = 1'b1;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(30);
    btn_level[2] = 1'b0;
    step(5);
    check("t5_held_no_event", int'(ev_valid), 0);
    btn_level[2] = 1'b1;
    step(3);
    btn_level[2] = 1'b0;
    push(2, 0, cyc + 2);
    drain("t5_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boton_event_arbiter.md
Name: boton_event_arbiter

Overview:
- Sits between the debounced button outputs and the mode/state machine.
- Classifies each button press as short or long.
- Queues one pending event per button and kind, and serializes events round-robin onto a single valid/ready channel.
- The main FSM sees exactly one clean event at a time, never raw levels.

Parameters:
- N_BTN, 4: number of button inputs (2..8).
- LONG_CYC, 5000: cycles a button must stay held to count as a long press (≥2).
- REPEAT_CYC, 2500: auto-repeat period in cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_level  input  N_BTN  debounced button levels; 1 = pressed.
- ev_ready  input  1  consumer accepts the event this cycle.
- ev_valid  output  1  an event is offered.
- ev_btn  output  clog2(N_BTN)  index of the button that produced the event.
- ev_long  output  1  1 = long press, 0 = short press.
- ev_overflow  output  1  sticky: an event was dropped because its slot was already pending.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - On reset: ev_valid=0, ev_btn=0, ev_long=0, ev_overflow=0.
  - All per-button FSMs go to IDLE, pending flags clear, RR pointer = 0.
  - btn_level history register loads the current btn_level, so a button held through reset generates no edge.
  - Reset mid-press or mid-offer discards everything; no event is emitted afterwards for that press.
- Per-button FSM, states IDLE, PRESSED, LONG_HELD:
  - IDLE → PRESSED on rising edge of btn_level[i]; press counter = 0.
  - PRESSED:
    - Counter increments each cycle while held.
    - Release with counter < LONG_CYC-1 → set short pending, go to IDLE.
    - Counter reaches LONG_CYC-1 while held → set long pending, go to LONG_HELD. The long event fires while the button is still held.
  - LONG_HELD → IDLE on release; no further event.
  - Counter width is clog2(LONG_CYC). It saturates and never wraps.
- Pending slots:
  - Each button has two flags, short and long.
  - Setting a flag that is already 1 drops the new event and sets ev_overflow, which stays set until reset.
- Arbiter, states IDLE and OFFER:
  - IDLE: if any flag is set, choose the first pending button at or after the RR pointer, wrapping modulo N_BTN.
    - If that button has both flags set, long wins.
    - Register ev_btn and ev_long, clear that flag, assert ev_valid next cycle, go to OFFER.
  - OFFER: ev_valid, ev_btn and ev_long stay stable until ev_valid && ev_ready.
    - On handshake: RR pointer = ev_btn+1 (wrapping), go to IDLE.
    - Minimum spacing between events is 2 cycles.
  - ev_ready asserted with ev_valid=0 is ignored.
- Simultaneous events:
  - Presses landing in the same cycle get distinct slots and are served in RR order.
  - A new event for the button being offered goes into its freshly cleared slot; this is not an overflow.
- Latency: 2 cycles from release (short) or from the threshold cycle (long) to ev_valid, when the arbiter is idle.

Optional Feature:
- Macro: BOTON_AUTOREPEAT_EN.
- Defined:
  - In LONG_HELD, a second counter re-sets the long pending flag every REPEAT_CYC cycles while the button stays held.
  - Overflow rules apply to repeats.
  - The repeat counter clears on entry to LONG_HELD.
- Undefined: LONG_HELD emits nothing; the repeat counter and REPEAT_CYC logic are absent.

Decomposition:
- Shared package boton_pkg holds:
  - per-button state encodings S_IDLE, S_PRESSED, S_LONG_HELD;
  - arbiter encodings A_IDLE, A_OFFER;
  - EV_SHORT=0, EV_LONG=1.
- One natural sub-module, boton_press_fsm: a single button's edge detect, counter and FSM, producing one-cycle short/long strobes. It is instantiated N_BTN times. Pending flags and RR arbitration stay in the top.

Test Plan:
Benches use N_BTN=4, LONG_CYC=20, REPEAT_CYC=10.
1. Short press: btn_level[2] high for 5 cycles, ev_ready=1 → ev_valid for exactly 1 cycle, 2 cycles after release, with ev_btn=2, ev_long=0.
2. Long press: btn_level[1] held 40 cycles → one event (btn 1, long) 2 cycles after the 20th held cycle; nothing on release. With BOTON_AUTOREPEAT_EN, further long events every 10 cycles while held (2 in total before release at 40).
3. Simultaneous short presses on buttons 0 and 3 released in the same cycle, with RR pointer = 2 → events in order btn 3, then btn 0. With ev_ready held low for 7 cycles, ev_btn and ev_long stay stable throughout.
4. Overflow: ev_ready=0; two short presses of btn 0 while its first event is still pending → ev_overflow=1; after ev_ready=1 only one btn-0 short event is delivered.
5. Reset mid-press: btn 3 held 10 cycles, reset pulsed 1 cycle, then released → no event, all outputs 0. A button held through reset produces no event until it is released and pressed again.
